// File: rtl/branch_predict_resolve_pkg.sv
// Shared types for the bimodal BTB predictor and EX-stage branch resolution.
// Branch funct3 codes, 2-bit counter states and the per-entry metadata.
package branch_predict_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Tag and target widths depend on XLEN, so they live beside this struct.
    typedef struct packed {
        logic valid;
        logic is_jump;
        ctr_e ctr;
    } btb_meta_t;

    function automatic ctr_e ctr_inc(input ctr_e c);
        case (c)
            CTR_SNT: return CTR_WNT;
            CTR_WNT: return CTR_WT;
            default: return CTR_ST;
        endcase
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        case (c)
            CTR_ST:  return CTR_WT;
            CTR_WT:  return CTR_WNT;
            default: return CTR_SNT;
        endcase
    endfunction

    function automatic logic ctr_taken(input ctr_e c);
        return (c == CTR_WT) || (c == CTR_ST);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Decodes branch funct3 against the ALU compare flags of rs1-rs2.
// Reserved funct3 encodings resolve as not taken.
module branch_cond_eval
    import branch_predict_resolve_pkg::*;
(
    input  logic [2:0] i_func3,
    input  logic       i_zero,
    input  logic       i_sign,
    input  logic       i_unsigned,
    output logic       o_cond
);

    always_comb begin
        o_cond = 1'b0;
        unique case (i_func3)
            F3_BEQ:  o_cond = i_zero;
            F3_BNE:  o_cond = ~i_zero;
            F3_BLT:  o_cond = i_sign & ~i_zero;
            F3_BGE:  o_cond = ~i_sign;
            F3_BLTU: o_cond = i_unsigned & ~i_zero;
            F3_BGEU: o_cond = ~i_unsigned;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal BTB predictor at fetch plus branch/jump resolution at EX.
// Mispredicts redirect the PC and flush IF/ID and ID/EX in the same cycle.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] FETCH_PC,
    output logic            PREDICT_TAKEN,
    output logic [XLEN-1:0] PREDICT_TARGET,
    input  logic            EX_VALID,
    input  logic [XLEN-1:0] EX_PC,
    input  logic            BRANCH,
    input  logic            JUMP,
    input  logic [2:0]      FUNC3,
    input  logic            ZERO,
    input  logic            SIGN,
    input  logic            UNSIGNED,
    input  logic [XLEN-1:0] BRANCH_ADDR,
    input  logic [XLEN-1:0] JUMP_ADDR,
    input  logic            EX_PRED_TAKEN,
    input  logic [XLEN-1:0] EX_PRED_TARGET,
    output logic            PC_MUX_CONTROL,
    output logic [XLEN-1:0] REDIRECT_ADDR,
    output logic            REG_FLUSH,
    output logic [CNT_W-1:0] BR_COUNT,
    output logic [CNT_W-1:0] MISPRED_COUNT
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_depth
        $error("BTB_ENTRIES must be a power of two and at least 2");
    end

    btb_meta_t        r_meta   [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  r_target [BTB_ENTRIES];
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_f_hit;
    logic             w_e_hit;
    logic             w_cond;
    logic             w_active;
    logic             w_taken;
    logic             w_tgt_diff;
    logic             w_mispred;
    logic [XLEN-1:0]  w_act_target;
    logic [XLEN-1:0]  w_pc_plus4;
    logic             w_unused_bits;

    assign w_unused_bits = ^{FETCH_PC[1:0], EX_PC[1:0]};

    // Fetch-side lookup
    assign w_f_idx = FETCH_PC[IDX_W+1:2];
    assign w_f_tag = FETCH_PC[XLEN-1:IDX_W+2];
    assign w_f_hit = ~RESET & r_meta[w_f_idx].valid
                   & (r_tag[w_f_idx] == w_f_tag);

    assign PREDICT_TAKEN  = w_f_hit & (r_meta[w_f_idx].is_jump
                          | ctr_taken(r_meta[w_f_idx].ctr));
    assign PREDICT_TARGET = w_f_hit ? r_target[w_f_idx] : '0;

    branch_cond_eval u_cond (
        .i_func3    (FUNC3),
        .i_zero     (ZERO),
        .i_sign     (SIGN),
        .i_unsigned (UNSIGNED),
        .o_cond     (w_cond)
    );

    // EX-side resolution; JUMP wins over BRANCH when both are set
    assign w_active     = EX_VALID & (BRANCH | JUMP);
    assign w_taken      = w_active & (JUMP | (BRANCH & w_cond));
    assign w_act_target = JUMP ? JUMP_ADDR : BRANCH_ADDR;
    assign w_pc_plus4   = EX_PC + XLEN'(4);
    assign w_tgt_diff   = (w_act_target != EX_PRED_TARGET);
    assign w_mispred    = w_active & ((w_taken != EX_PRED_TAKEN)
                        | (w_taken & EX_PRED_TAKEN & w_tgt_diff));

    assign PC_MUX_CONTROL = w_mispred;
    assign REG_FLUSH      = w_mispred;
    assign REDIRECT_ADDR  = w_taken ? w_act_target : w_pc_plus4;

    assign w_e_idx = EX_PC[IDX_W+1:2];
    assign w_e_tag = EX_PC[XLEN-1:IDX_W+2];
    assign w_e_hit = r_meta[w_e_idx].valid & (r_tag[w_e_idx] == w_e_tag);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_meta[i].valid   <= 1'b0;
                r_meta[i].is_jump <= 1'b0;
                r_meta[i].ctr     <= CTR_WNT;
                r_tag[i]          <= '0;
                r_target[i]       <= '0;
            end
        end else if (w_active) begin
            if (w_taken) begin
                r_target[w_e_idx]       <= w_act_target;
                r_meta[w_e_idx].is_jump <= JUMP;
                if (w_e_hit) begin
                    r_meta[w_e_idx].ctr <= ctr_inc(r_meta[w_e_idx].ctr);
                end else begin
                    r_meta[w_e_idx].valid <= 1'b1;
                    r_meta[w_e_idx].ctr   <= CTR_WT;
                    r_tag[w_e_idx]        <= w_e_tag;
                end
            end else if (w_e_hit) begin
                r_meta[w_e_idx].ctr <= ctr_dec(r_meta[w_e_idx].ctr);
            end
        end
    end

    // Performance counters stick at all-ones
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_active && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispred && (r_mis_cnt != '1)) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign BR_COUNT      = r_br_cnt;
    assign MISPRED_COUNT = r_mis_cnt;

endmodule
